// File: rtl/cardinal_nic.sv
// cardinal_nic: network interface between one Cardinal core and its mesh
// router port. It holds a one-packet input buffer (router -> core) and a
// one-packet output buffer (core -> router). The core reaches both through
// a 2-bit memory-mapped register space. The router side uses a send/ready
// handshake.
//
// Optional feature macro: CARDINAL_NIC_POLARITY_CHECK_EN
//   When it is defined, an outgoing packet leaves only when its VC bit
//   (bit 63) matches net_polarity.
//   When it is undefined, net_polarity is ignored.
module cardinal_nic (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic [63:0] d_in,
    output logic [63:0] d_out,
    input  logic        nicEn,
    input  logic        nicEnWr,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [63:0] net_di,
    output logic        net_so,
    input  logic        net_ro,
    output logic [63:0] net_do,
    input  logic        net_polarity
);

    typedef enum logic [1:0] {
        ADDR_IN_BUF   = 2'b00,
        ADDR_IN_STAT  = 2'b01,
        ADDR_OUT_BUF  = 2'b10,
        ADDR_OUT_STAT = 2'b11
    } reg_addr_e;

    logic [63:0] in_buf_q,   in_buf_d;
    logic        in_full_q,  in_full_d;
    logic [63:0] out_buf_q,  out_buf_d;
    logic        out_full_q, out_full_d;
    logic [63:0] d_out_q,    d_out_d;
    logic        net_so_q,   net_so_d;
    logic [63:0] net_do_q,   net_do_d;

    logic load, store, capture, send, polarity_ok;

`ifdef CARDINAL_NIC_POLARITY_CHECK_EN
    assign polarity_ok = (out_buf_q[63] == net_polarity);
`else
    assign polarity_ok = 1'b1;
`endif

    // The router may deliver only while the input buffer is empty. Readiness
    // comes from registered state, so a read that empties the buffer does not
    // allow a capture until the following cycle.
    assign net_ri  = !in_full_q;
    assign capture = net_si && net_ri;
    assign load    = nicEn && !nicEnWr;
    assign store   = nicEn && nicEnWr && (reg_addr_e'(addr) == ADDR_OUT_BUF);
    assign send    = out_full_q && net_ro && polarity_ok;

    assign d_out  = d_out_q;
    assign net_so = net_so_q;
    assign net_do = net_do_q;

    // Next-state logic for both buffers, the load data register and the router outputs.
    always_comb begin
        // NOTE: every _d defaults to hold (or to 0 for the pulse), so no path leaves one unassigned and no latch is inferred.
        in_buf_d   = in_buf_q;
        in_full_d  = in_full_q;
        out_buf_d  = out_buf_q;
        out_full_d = out_full_q;
        d_out_d    = d_out_q;
        net_so_d   = 1'b0;
        net_do_d   = net_do_q;

        if (capture) begin
            in_buf_d  = net_di;
            in_full_d = 1'b1;
        end

        if (load) begin
            unique case (reg_addr_e'(addr))
                ADDR_IN_BUF: begin
                    d_out_d = in_buf_q;
                    // Clear only when full. A capture can happen in this same
                    // cycle while the buffer is empty, and it must not be undone.
                    if (in_full_q) in_full_d = 1'b0;
                end
                ADDR_IN_STAT:  d_out_d = {63'b0, in_full_q};
                ADDR_OUT_BUF:  d_out_d = out_buf_q;
                ADDR_OUT_STAT: d_out_d = {63'b0, out_full_q};
                default:       d_out_d = d_out_q;
            endcase
        end

        // A store while full is dropped. This also covers a store in the same
        // cycle as a send, because out_full_q is still set in that cycle.
        if (store && !out_full_q) begin
            out_buf_d  = d_in;
            out_full_d = 1'b1;
        end

        if (send) begin
            net_so_d   = 1'b1;
            net_do_d   = out_buf_q;
            out_full_d = 1'b0;
        end
    end

    // State register with synchronous reset. A reset discards both buffered packets.
    always_ff @(posedge clk) begin
        // NOTE: the 64-bit buffers are plain flops, not memory arrays, so they are reset along with the flags.
        if (reset) begin
            in_buf_q   <= '0;
            in_full_q  <= 1'b0;
            out_buf_q  <= '0;
            out_full_q <= 1'b0;
            d_out_q    <= '0;
            net_so_q   <= 1'b0;
            net_do_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the pre-edge values.
            in_buf_q   <= in_buf_d;
            in_full_q  <= in_full_d;
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
            d_out_q    <= d_out_d;
            net_so_q   <= net_so_d;
            net_do_q   <= net_do_d;
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed bench for cardinal_nic.
// It uses a table of per-cycle vectors with hand-computed expected outputs,
// followed by hand-written sequences for reset and polarity behaviour.
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicEnWr;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    int checks = 0;
    int errors = 0;

    cardinal_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicEnWr      (nicEnWr),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        wr;
        logic [1:0]  addr;
        logic [63:0] d_in;
        logic        si;
        logic [63:0] di;
        logic        ro;
        logic        pol;
        logic [63:0] exp_dout;
        logic        exp_ri;
        logic        exp_so;
        logic [63:0] exp_do;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic wr, input logic [1:0] a, input logic [63:0] din,
                       input logic si, input logic [63:0] di, input logic ro, input logic pol,
                       input logic [63:0] edout, input logic eri, input logic eso, input logic [63:0] edo);
        vec_t v;
        v.en = en; v.wr = wr; v.addr = a; v.d_in = din; v.si = si; v.di = di;
        v.ro = ro; v.pol = pol; v.exp_dout = edout; v.exp_ri = eri; v.exp_so = eso; v.exp_do = edo;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic en, input logic wr, input logic [1:0] a, input logic [63:0] din,
                         input logic si, input logic [63:0] di, input logic ro, input logic pol);
        nicEn = en; nicEnWr = wr; addr = a; d_in = din;
        net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
    endtask

    // Advance one rising edge, then move 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [63:0] edout, input logic eri,
                              input logic eso, input logic [63:0] edo);
        check({tag, " d_out"},  d_out,          edout);
        check({tag, " net_ri"}, {63'b0, net_ri}, {63'b0, eri});
        check({tag, " net_so"}, {63'b0, net_so}, {63'b0, eso});
        check({tag, " net_do"}, net_do,         edo);
    endtask

    localparam logic [63:0] DEAD = 64'hDEADBEEFDEADBEEF;
    localparam logic [63:0] CAFE = 64'hCAFEBABECAFEBABE;
    localparam logic [63:0] A5   = 64'hA5A5A5A5A5A5A5A5;
    localparam logic [63:0] P012 = 64'h0123456789ABCDEF;
    localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] P555 = 64'h5555555555555555;
    localparam logic [63:0] P777 = 64'h7777777777777777;
    localparam logic [63:0] PAAA = 64'h2AAAAAAAAAAAAAAA;
    localparam logic [63:0] PBBB = 64'h3BBBBBBBBBBBBBBB;
    localparam logic [63:0] PCCC = 64'h4CCCCCCCCCCCCCCC;
    localparam logic [63:0] VC1  = 64'h8000000000000042;

    initial begin
        // Field order: en wr addr d_in | si di | ro pol || exp d_out ri so do
        // For every send, pol equals the VC bit of the packet, so the same table
        // also holds when the polarity check is built in.
        add(1,0,2'b11,0,    0,0,    0,1,  0,    1,0,0);    // out status after reset
        add(1,1,2'b10,DEAD, 0,0,    0,1,  0,    1,0,0);    // store DEAD
        add(1,0,2'b11,0,    0,0,    0,1,  1,    1,0,0);    // out status = 1
        add(0,0,2'b00,0,    0,0,    1,1,  1,    1,1,DEAD); // send pulse
        add(1,0,2'b11,0,    0,0,    0,1,  0,    1,0,DEAD); // status cleared, pulse over
        add(1,0,2'b10,0,    0,0,    0,1,  DEAD, 1,0,DEAD); // out_buf readback
        add(1,1,2'b10,CAFE, 0,0,    0,1,  DEAD, 1,0,DEAD); // store CAFE, router blocked
        add(0,0,2'b00,0,    0,0,    0,1,  DEAD, 1,0,DEAD); // still blocked
        add(1,0,2'b11,0,    0,0,    0,1,  1,    1,0,DEAD); // status stays 1
        add(0,0,2'b00,0,    0,0,    1,1,  1,    1,1,CAFE); // send CAFE
        add(1,0,2'b11,0,    0,0,    0,1,  0,    1,0,CAFE);
        add(0,0,2'b00,0,    1,A5,   0,1,  0,    0,0,CAFE); // router delivers A5
        add(1,0,2'b01,0,    1,ONES, 0,1,  1,    0,0,CAFE); // delivery while full ignored
        add(1,0,2'b00,0,    0,0,    0,1,  A5,   1,0,CAFE); // read A5, clears in_full
        add(1,0,2'b01,0,    0,0,    0,1,  0,    1,0,CAFE);
        add(1,0,2'b00,0,    0,0,    0,1,  A5,   1,0,CAFE); // stale read
        add(1,0,2'b01,0,    0,0,    0,1,  0,    1,0,CAFE); // status stays 0
        add(1,1,2'b10,P012, 0,0,    0,0,  0,    1,0,CAFE); // store 0123..
        add(1,1,2'b10,ONES, 0,0,    0,0,  0,    1,0,CAFE); // store while full dropped
        add(1,0,2'b11,0,    0,0,    0,0,  1,    1,0,CAFE);
        add(1,0,2'b10,0,    0,0,    0,0,  P012, 1,0,CAFE); // buffer unchanged
        add(0,0,2'b00,0,    0,0,    1,0,  P012, 1,1,P012); // send 0123..
        add(0,0,2'b00,0,    0,0,    1,0,  P012, 1,0,P012); // one-cycle pulse, do holds
        add(1,1,2'b10,P555, 0,0,    0,0,  P012, 1,0,P012); // store 5555
        add(1,1,2'b10,P777, 0,0,    1,0,  P012, 1,1,P555); // store during send dropped
        add(1,0,2'b10,0,    0,0,    0,0,  P555, 1,0,P555); // out_buf still 5555
        add(1,0,2'b11,0,    0,0,    0,0,  0,    1,0,P555);
        add(1,1,2'b00,ONES, 0,0,    0,0,  0,    1,0,P555); // store to addr 00 ignored
        add(1,0,2'b11,0,    0,0,    0,0,  0,    1,0,P555);
        add(0,0,2'b00,0,    1,PAAA, 0,0,  0,    0,0,P555); // capture AAAA
        add(1,0,2'b00,0,    1,PBBB, 0,0,  PAAA, 1,0,P555); // read clears, no same-cycle capture
        add(1,0,2'b00,0,    0,0,    0,0,  PAAA, 1,0,P555); // BBBB was not captured
        add(0,0,2'b00,0,    1,PCCC, 0,0,  PAAA, 0,0,P555); // capture next cycle works
        add(1,0,2'b00,0,    0,0,    0,0,  PCCC, 1,0,P555);

        drive(0,0,2'b00,0,0,0,0,0);
        reset = 1'b1;
        tick();
        tick();
        check_outs("reset", 0, 1, 0, 0);
        reset = 1'b0;
        tick();
        check_outs("release", 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].d_in,
                  vecs[i].si, vecs[i].di, vecs[i].ro, vecs[i].pol);
            tick();
            check_outs($sformatf("v%0d", i), vecs[i].exp_dout, vecs[i].exp_ri,
                       vecs[i].exp_so, vecs[i].exp_do);
        end

        // Reset in the middle of operation: both buffers hold packets when reset arrives.
        drive(1,1,2'b10,CAFE,1,A5,0,0);
        tick();
        check_outs("pre-reset", PCCC, 0, 0, P555);
        drive(0,0,2'b00,0,0,0,0,0);
        reset = 1'b1;
        tick();
        check_outs("mid-reset", 0, 1, 0, 0);
        reset = 1'b0;
        drive(1,0,2'b11,0,0,0,1,0);
        tick();
        check_outs("post-reset out status", 0, 1, 0, 0);
        drive(1,0,2'b01,0,0,0,1,0);
        tick();
        check_outs("post-reset in status", 0, 1, 0, 0);
        drive(1,0,2'b10,0,0,0,1,0);
        tick();
        check_outs("post-reset out_buf", 0, 1, 0, 0);
        drive(1,0,2'b00,0,0,0,1,0);
        tick();
        check_outs("post-reset in_buf", 0, 1, 0, 0);

        // Polarity: the packet has VC=1, the router is ready, and polarity is 0.
        drive(1,1,2'b10,VC1,0,0,0,0);
        tick();
        drive(0,0,2'b00,0,0,0,1,0);
        tick();
`ifdef CARDINAL_NIC_POLARITY_CHECK_EN
        check_outs("pol mismatch wait", 0, 1, 0, 0);
        tick();
        check_outs("pol mismatch wait2", 0, 1, 0, 0);
        net_polarity = 1'b1;
        tick();
        check_outs("pol match send", 0, 1, 1, VC1);
`else
        check_outs("pol ignored send", 0, 1, 1, VC1);
`endif
        drive(1,0,2'b11,0,0,0,0,0);
        tick();
        check_outs("pol after send", 0, 1, 0, VC1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
